// File: rtl/ber_sweep_logger.sv
// ber_sweep_logger: sweeps SNR points and logs bit/frame errors of decoded frames per point
module ber_sweep_logger #(
    parameter int N                   = 204,
    parameter int SNR_PACKET_SIZE     = 4,
    parameter int ERR_CNT_PACKET_SIZE = 28,
    parameter int FRAME_CNT_WIDTH     = 20,
    parameter int CHUNK               = 8
) (
    input  logic                                                   sys_clk,
    input  logic                                                   sys_rst,
    input  logic                                                   start,
    input  logic [SNR_PACKET_SIZE-1:0]                             snr_start,
    input  logic [SNR_PACKET_SIZE-1:0]                             snr_stop,
    input  logic [FRAME_CNT_WIDTH-1:0]                             frames_per_snr,
    input  logic [FRAME_CNT_WIDTH-1:0]                             warmup_frames,
    input  logic [N-1:0]                                           ref_codeword,
    input  logic [N-1:0]                                           hard_decision,
    input  logic                                                   frame_valid,
    output logic                                                   frame_ready,
    output logic [SNR_PACKET_SIZE-1:0]                             snr_sel,
    output logic [ERR_CNT_PACKET_SIZE+FRAME_CNT_WIDTH+SNR_PACKET_SIZE-1:0] result_data,
    output logic                                                   result_valid,
    input  logic                                                   result_ready,
    output logic                                                   busy,
    output logic                                                   done
);
    localparam int NCH = (N + CHUNK - 1) / CHUNK;
    localparam int CW  = $clog2(CHUNK + 1);
    localparam int SW  = $clog2(N + 1);
    localparam int FW  = FRAME_CNT_WIDTH;
    localparam int SNW = SNR_PACKET_SIZE;
    localparam int EW  = ERR_CNT_PACKET_SIZE;

    typedef enum logic [2:0] {IDLE, WARMUP, COUNT, DRAIN, REPORT, DONE} state_t;

    state_t          state;
    logic [SNW-1:0]  stop_q;
    logic [FW-1:0]   fps_q, warm_q, wcnt, fcnt, frame_err_cnt;
    logic [EW-1:0]   bit_err_acc;
    logic [EW:0]     acc_sum;
    logic [NCH*CHUNK-1:0] xv;
    logic [CW-1:0]   c1 [NCH];
    logic [CW-1:0]   s1_cnt [NCH];
    logic [SW-1:0]   c2, s2_sum;
    logic            s1_valid, s2_valid, accept, idle_like, clr;

    assign accept    = frame_valid & frame_ready;
    assign idle_like = (state == IDLE) || (state == DONE);
    assign clr       = (idle_like && start) || (state == REPORT && result_ready);
    assign xv        = (NCH*CHUNK)'(hard_decision ^ ref_codeword);
    assign acc_sum   = {1'b0, bit_err_acc} + (EW+1)'(s2_sum);
    assign result_data = result_valid ? {bit_err_acc, frame_err_cnt, snr_sel} : '0;

    // per-chunk popcount of the error vector, last chunk zero-padded
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            c1[i] = '0;
            for (int j = 0; j < CHUNK; j++) c1[i] = c1[i] + CW'(xv[i*CHUNK+j]);
        end
    end

    // sum of the registered chunk counts into one frame error count
    always_comb begin
        c2 = '0;
        for (int i = 0; i < NCH; i++) c2 = c2 + SW'(s1_cnt[i]);
    end

    // popcount pipe data stages; qualified by the valid bits below
    always_ff @(posedge sys_clk) begin
        s1_cnt <= c1;
        s2_sum <= c2;
    end

    // popcount pipe valid bits; only COUNT acceptances enter the pipe
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= accept && state == COUNT;
            s2_valid <= s1_valid;
        end
    end

    // saturating bit-error and frame-error accumulators
    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr) begin
            bit_err_acc   <= '0;
            frame_err_cnt <= '0;
        end else if (s2_valid) begin
            bit_err_acc   <= acc_sum[EW] ? '1 : acc_sum[EW-1:0];
            frame_err_cnt <= (s2_sum != '0 && !(&frame_err_cnt)) ? frame_err_cnt + FW'(1) : frame_err_cnt;
        end
    end

    // sweep control FSM with registered handshake and status outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            frame_ready  <= 1'b0;
            result_valid <= 1'b0;
            snr_sel      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            stop_q       <= '0;
            fps_q        <= '0;
            warm_q       <= '0;
            wcnt         <= '0;
            fcnt         <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    snr_sel     <= snr_start;
                    stop_q      <= snr_stop;
                    fps_q       <= (frames_per_snr == '0) ? FW'(1) : frames_per_snr;
                    warm_q      <= warmup_frames;
                    wcnt        <= '0;
                    fcnt        <= '0;
                    frame_ready <= 1'b1;
                    busy        <= 1'b1;
                    done        <= 1'b0;
                    state       <= (warmup_frames == '0) ? COUNT : WARMUP;
                end
                WARMUP: if (accept) begin
                    wcnt  <= (wcnt == warm_q - FW'(1)) ? '0 : wcnt + FW'(1);
                    fcnt  <= '0;
                    state <= (wcnt == warm_q - FW'(1)) ? COUNT : WARMUP;
                end
                COUNT: if (accept) begin
                    fcnt <= fcnt + FW'(1);
                    if (fcnt == fps_q - FW'(1)) begin
                        frame_ready <= 1'b0;
                        state       <= DRAIN;
                    end
                end
                // stage 2 retires on this edge when stage 1 is already empty
                DRAIN: if (!s1_valid) begin
                    result_valid <= 1'b1;
                    state        <= REPORT;
                end
                REPORT: if (result_ready) begin
                    result_valid <= 1'b0;
                    if (snr_sel == stop_q) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        snr_sel     <= snr_sel + SNW'(1);
                        wcnt        <= '0;
                        fcnt        <= '0;
                        frame_ready <= 1'b1;
                        state       <= (warm_q == '0) ? COUNT : WARMUP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ber_sweep_logger.sv
// tb_ber_sweep_logger: directed scoreboard bench for ber_sweep_logger
module tb_ber_sweep_logger;
    localparam int N = 204;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_m = 1'b0, start_s = 1'b0;
    logic [3:0]   snr_start = '0, snr_stop = '0;
    logic [19:0]  fps = '0, wu = '0;
    logic [N-1:0] ref_cw = '0, hd = '0;
    logic         fv = 1'b0, rdy = 1'b1;

    logic         fr, rv, busy, done;
    logic [3:0]   snr;
    logic [51:0]  rd;
    logic         fr_s, rv_s, busy_s, done_s;
    logic [3:0]   snr_s;
    logic [31:0]  rd_s;

    logic [51:0]  q  [$];
    logic [31:0]  qs [$];
    int           n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    ber_sweep_logger dut (
        .sys_clk(clk), .sys_rst(rst), .start(start_m), .snr_start(snr_start), .snr_stop(snr_stop),
        .frames_per_snr(fps), .warmup_frames(wu), .ref_codeword(ref_cw), .hard_decision(hd),
        .frame_valid(fv), .frame_ready(fr), .snr_sel(snr), .result_data(rd), .result_valid(rv),
        .result_ready(rdy), .busy(busy), .done(done)
    );

    ber_sweep_logger #(.ERR_CNT_PACKET_SIZE(8)) dut_sat (
        .sys_clk(clk), .sys_rst(rst), .start(start_s), .snr_start(snr_start), .snr_stop(snr_stop),
        .frames_per_snr(fps), .warmup_frames(wu), .ref_codeword(ref_cw), .hard_decision(hd),
        .frame_valid(fv), .frame_ready(fr_s), .snr_sel(snr_s), .result_data(rd_s), .result_valid(rv_s),
        .result_ready(1'b1), .busy(busy_s), .done(done_s)
    );

    function automatic logic [51:0] pk(input int e, input int f, input int s);
        return {28'(e), 20'(f), 4'(s)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // main DUT monitor: every presented packet must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && rv) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pkt: unexpected packet %0h", rd);
            end else begin
                chk("pkt", 64'(rd), 64'(q[0]));
                if (rdy) void'(q.pop_front());
            end
        end
    end

    // narrow-accumulator DUT monitor
    always @(negedge clk) begin
        if (!rst && rv_s) begin
            if (qs.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pkt_sat: unexpected packet %0h", rd_s);
            end else begin
                chk("pkt_sat", 64'(rd_s), 64'(qs[0]));
                void'(qs.pop_front());
            end
        end
    end

    task automatic do_start(input int ss, input int se, input int f, input int w, input bit s);
        snr_start = 4'(ss);
        snr_stop  = 4'(se);
        fps       = 20'(f);
        wu        = 20'(w);
        if (s) start_s = 1'b1; else start_m = 1'b1;
        tick();
        start_m = 1'b0;
        start_s = 1'b0;
        chk("start_ready", 64'(s ? fr_s : fr), 64'(1));
        chk("start_busy", 64'(s ? busy_s : busy), 64'(1));
        chk("start_done_clr", 64'(s ? done_s : done), 64'(0));
    endtask

    task automatic send(input int k, input bit s);
        logic [N-1:0] ones;
        int i;
        ones = '1;
        hd   = ref_cw ^ (ones >> (N - k));
        fv   = 1'b1;
        i    = 0;
        while (!(s ? fr_s : fr) && i < 200) begin
            tick();
            i++;
        end
        if (i >= 200) chk("send_timeout", 64'(0), 64'(1));
        tick();
        fv = 1'b0;
        hd = '0;
    endtask

    task automatic wait_done(input bit s);
        int i;
        i = 0;
        while (!(s ? done_s : done) && i < 300) begin
            tick();
            i++;
        end
        chk("done", 64'(s ? done_s : done), 64'(1));
        chk("done_busy", 64'(s ? busy_s : busy), 64'(0));
    endtask

    task automatic wait_valid();
        int i;
        i = 0;
        while (!rv && i < 50) begin
            tick();
            i++;
        end
        chk("valid_rise", 64'(rv), 64'(1));
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_ready", 64'(fr), 64'(0));
        chk("rst_valid", 64'(rv), 64'(0));
        chk("rst_data", 64'(rd), 64'(0));
        chk("rst_snr", 64'(snr), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        rst = 1'b0;
        tick();

        // single error-free point, with report latency
        q.push_back(pk(0, 0, 10));
        do_start(10, 10, 8, 0, 0);
        for (int i = 0; i < 8; i++) send(0, 0);
        chk("lat_t1", 64'(rv), 64'(0));
        chk("lat_ready_drop", 64'(fr), 64'(0));
        tick();
        chk("lat_t2", 64'(rv), 64'(0));
        tick();
        chk("lat_t3", 64'(rv), 64'(1));
        tick();
        chk("done_t4", 64'(done), 64'(1));

        // known errors against a nonzero reference, warm-up excluded
        ref_cw = {51{4'hA}};
        q.push_back(pk(208, 3, 5));
        do_start(5, 5, 4, 2, 0);
        send(50, 0);
        send(50, 0);
        send(3, 0);
        send(0, 0);
        send(204, 0);
        send(1, 0);
        wait_done(0);
        ref_cw = '0;

        // sweep 2..4 with backpressure at every report
        rdy = 1'b0;
        for (int s = 2; s <= 4; s++) q.push_back(pk(5 * s, 5, s));
        do_start(2, 4, 5, 0, 0);
        for (int s = 2; s <= 4; s++) begin
            chk("sweep_snr", 64'(snr), 64'(s));
            chk("sweep_ready", 64'(fr), 64'(1));
            for (int f = 0; f < 5; f++) send(s, 0);
            wait_valid();
            repeat (10) tick();
            chk("stall_snr", 64'(snr), 64'(s));
            chk("stall_valid", 64'(rv), 64'(1));
            rdy = 1'b1;
            tick();
            rdy = 1'b0;
        end
        chk("sweep_done", 64'(done), 64'(1));
        rdy = 1'b1;

        // wrapping sweep with a zero frame budget
        q.push_back(pk(7, 1, 15));
        q.push_back(pk(7, 1, 0));
        q.push_back(pk(7, 1, 1));
        do_start(15, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) send(7, 0);
        wait_done(0);

        // saturation on the 8-bit accumulator instance
        qs.push_back({8'd255, 20'd2, 4'd6});
        do_start(6, 6, 2, 0, 1);
        send(204, 1);
        send(204, 1);
        wait_done(1);

        // stray start while busy, then reset mid-count
        do_start(3, 3, 8, 0, 0);
        send(1, 0);
        snr_start = 4'd9;
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        chk("stray_snr", 64'(snr), 64'(3));
        chk("stray_busy", 64'(busy), 64'(1));
        send(1, 0);
        send(1, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_ready", 64'(fr), 64'(0));
        chk("mid_rst_valid", 64'(rv), 64'(0));
        chk("mid_rst_data", 64'(rd), 64'(0));
        chk("mid_rst_snr", 64'(snr), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        rst = 1'b0;
        repeat (10) tick();
        chk("no_pkt_after_rst", 64'(rv), 64'(0));

        // fresh point after reset sees a clean pipe
        q.push_back(pk(0, 0, 1));
        do_start(1, 1, 1, 0, 0);
        send(0, 0);
        wait_done(0);
        repeat (3) tick();
        chk("q_empty", 64'(q.size()), 64'(0));
        chk("qs_empty", 64'(qs.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ber_sweep_logger.md
# ber_sweep_logger

Parametrised bit/frame error logger that sits between the LDPC decoder's hard-decision output and the result FIFO. It sweeps an SNR index over a programmed range and drives `snr_sel` to the sigma mux feeding the symbol generator. For each SNR point it discards a programmable number of warm-up frames, then counts bit errors and frame errors over a fixed frame budget. At the end of each point it emits one result packet over a valid/ready handshake.

## Interface
Parameters:
- `N`, 204, codeword length (bits per hard-decision frame).
- `SNR_PACKET_SIZE`, 4, SNR index width.
- `ERR_CNT_PACKET_SIZE`, 28, bit-error accumulator width.
- `FRAME_CNT_WIDTH`, 20, frame counter and frame-error counter width.
- `CHUNK`, 8, popcount first-stage chunk width; the last chunk is zero-padded.

Ports:
- `sys_clk`  in  1  sole clock.
- `sys_rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that latches the configuration and begins a sweep. Honoured only in IDLE or DONE.
- `snr_start`, `snr_stop`  in  SNR_PACKET_SIZE  first and last SNR index of the sweep.
- `frames_per_snr`  in  FRAME_CNT_WIDTH  frames counted per SNR point. A value of 0 is treated as 1.
- `warmup_frames`  in  FRAME_CNT_WIDTH  frames discarded after each SNR change. 0 means no warm-up.
- `ref_codeword`  in  N  transmitted codeword to compare against. Tie to 0 for the all-zero codeword.
- `hard_decision`  in  N  decoder output frame.
- `frame_valid`  in  1  `hard_decision` is valid this cycle.
- `frame_ready`  out  1  the block accepts a frame this cycle.
- `snr_sel`  out  SNR_PACKET_SIZE  current SNR index, used to select sigma.
- `result_data`  out  ERR_CNT_PACKET_SIZE+FRAME_CNT_WIDTH+SNR_PACKET_SIZE  packet laid out as {bit_err_acc, frame_err_cnt, snr}.
- `result_valid`  out  1  result packet is valid.
- `result_ready`  in  1  result FIFO can accept the packet.
- `busy`  out  1  high in any state other than IDLE and DONE.
- `done`  out  1  sweep complete; held until the next `start` or reset.

## Operation
- **States:** IDLE, WARMUP, COUNT, DRAIN, REPORT, DONE.
- **IDLE / DONE + `start`:**
  - Latch all configuration inputs and set `snr_sel` = `snr_start`.
  - Clear both accumulators and the frame counter.
  - Next state is WARMUP, or COUNT if the latched warm-up count is 0.
- **WARMUP:**
  - `frame_ready` = 1.
  - Each accepted frame (`frame_valid & frame_ready`) increments the warm-up counter.
  - Warm-up frames are not sent into the popcount pipe.
  - After `warmup_frames` acceptances, go to COUNT with the frame counter cleared.
- **COUNT:**
  - `frame_ready` = 1 while accepted < `frames_per_snr`.
  - Each accepted frame enters the popcount pipe as `hard_decision ^ ref_codeword`.
  - When the last frame is accepted, `frame_ready` drops the next cycle and the state goes to DRAIN.
- **Popcount pipe:**
  - Stage 1 registers a per-CHUNK popcount.
  - Stage 2 registers the frame sum (width clog2(N+1)) together with a valid bit.
  - Stage-2 valid adds the sum to `bit_err_acc`, and increments `frame_err_cnt` if the sum is nonzero.
- **Saturation:** both accumulators saturate at all-ones and never wrap.
- **DRAIN:** wait until both pipe valid bits are 0, then go to REPORT.
- **REPORT:**
  - `result_valid` = 1 with `result_data` stable until `result_ready` is sampled high.
  - On the transfer: if `snr_sel` == latched `snr_stop`, go to DONE. Otherwise set `snr_sel` = `snr_sel`+1 (modulo 2^SNR_PACKET_SIZE, so a stop index below the start index wraps), clear the accumulators and counters, and go to WARMUP or COUNT.
- **`start` outside IDLE/DONE:** ignored.
- **`frame_valid` while `frame_ready` = 0:** the frame is dropped and never counted.

## Timing
- **Reset values:** state IDLE, `frame_ready` 0, `result_valid` 0, `result_data` 0, `snr_sel` 0, `busy` 0, `done` 0. Accumulators and pipe valid bits are 0.
- **Reset mid-sweep:** everything, including the pipe, returns to the reset values on the next edge. No packet is emitted.
- **Start latency:** `start` at cycle t gives `frame_ready` = 1 and `busy` = 1 at t+1.
- **Popcount latency:** a frame accepted at cycle t enters the accumulators at the edge ending cycle t+2.
- **Report latency:** after the last COUNT acceptance at t, `result_valid` rises at t+3 (one cycle to DRAIN, pipe empty, then REPORT).
- **Throughput:** one frame per cycle in WARMUP and COUNT.
- **SNR change:** `snr_sel` changes only on the cycle after a REPORT transfer.
- **Next point:** `frame_ready` for the next point asserts the cycle after the transfer.
- **`done`:** rises on the cycle after the final transfer and clears on the cycle after `start` is accepted.

## Test plan
- **Single point, error-free:** `snr_start`=`snr_stop`=10, warm-up 0, 8 frames of all-zero `hard_decision` with `ref_codeword`=0 -> one packet {0,0,10}, then `done`=1.
- **Known errors:** 4 frames with 3, 0, 204, 1 bit errors, warm-up 2 frames containing 50 errors each -> packet {208,3,snr}; warm-up errors are excluded.
- **Sweep with backpressure:** sweep 2..4, 5 frames each, `result_ready` held low for 10 cycles at each REPORT -> three packets with snr 2, 3, 4 in order; `result_data` stable while stalled; `snr_sel` steps only after each transfer.
- **Wrap and zero budget:** `snr_start`=15, `snr_stop`=1, `frames_per_snr`=0 -> packets for snr 15, 0, 1, each counting exactly 1 frame.
- **Saturation:** ERR_CNT_PACKET_SIZE=8, 2 frames of 204 errors -> `bit_err_acc`=255, `frame_err_cnt`=2.
- **Reset and stray inputs:** `sys_rst` asserted in COUNT after 3 of 8 frames -> all outputs at reset values next cycle, no packet; a `start` pulse issued while busy has no effect.
